// File: rtl/rx_vc_unpacker_pkg.sv
// Shared types for the RX VC unpacker: slot record, drain FSM states, slot-priority helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_vc_unpacker_pkg;

  localparam int WORD_WIDTH  = 64;
  localparam int VC_NO_WIDTH = 4;
  localparam int RX_SLOTS    = 7;
  localparam int SLOT_IDX_W  = $clog2(RX_SLOTS);

  typedef struct packed {
    logic [VC_NO_WIDTH-1:0] vc;
    logic [WORD_WIDTH-1:0]  data;
  } rx_slot_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } rx_state_e;

  // Index of the lowest set bit; 0 when the mask is empty (caller qualifies with |mask).
  function automatic logic [SLOT_IDX_W-1:0] first_set(input logic [RX_SLOTS-1:0] mask);
    logic [SLOT_IDX_W-1:0] idx;
    logic                  found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < RX_SLOTS; i++) begin
      if (mask[i] && !found) begin
        idx   = SLOT_IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rx_vc_unpacker_if.sv
// Bundles the block input, per-VC word streams, credit returns and status of the RX VC unpacker.
// Latency: n/a (wiring only).
// Backpressure: mib_valid/mib_ready for blocks, vc_valid/vc_ready per VC.
// Ports: mib_data/mib_vc_no/mib_valid/mib_ready (block in), vc_data/vc_valid/vc_ready (per-VC out),
//        cred_ret (credit pulses), stall (slot blocked), stat_words (per-VC word counts).
// slave = the unpacker, master = link layer plus VC consumers.
interface rx_vc_unpacker_if #(
  parameter int NUM_VC     = 14,
  parameter int STAT_WIDTH = 32
);
  import rx_vc_unpacker_pkg::*;

  logic [RX_SLOTS-1:0][WORD_WIDTH-1:0]  mib_data;
  logic [RX_SLOTS-1:0][VC_NO_WIDTH-1:0] mib_vc_no;
  logic                                 mib_valid;
  logic                                 mib_ready;
  logic [NUM_VC-1:0][WORD_WIDTH-1:0]    vc_data;
  logic [NUM_VC-1:0]                    vc_valid;
  logic [NUM_VC-1:0]                    vc_ready;
  logic [NUM_VC-1:0]                    cred_ret;
  logic                                 stall;
  logic [NUM_VC-1:0][STAT_WIDTH-1:0]    stat_words;

  modport slave (
    input  mib_data, mib_vc_no, mib_valid, vc_ready,
    output mib_ready, vc_data, vc_valid, cred_ret, stall, stat_words
  );

  modport master (
    output mib_data, mib_vc_no, mib_valid, vc_ready,
    input  mib_ready, vc_data, vc_valid, cred_ret, stall, stat_words
  );

endinterface

// File: rtl/rx_vc_unpacker_fifo.sv
// First-word-fall-through synchronous FIFO holding the words of one VC.
// Latency: word visible on dout/valid the cycle after push.
// Backpressure: push ignored while full (full is registered), pop ignored while empty.
// Ports: clk, rst_n, push/din (write), pop (read), dout/valid (head word), full.
module rx_vc_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign valid   = !empty;
  // Gate the head word so stale storage never shows while empty.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observed through valid pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rx_vc_unpacker.sv
// Unpacks 7-slot RX blocks into per-VC FWFT FIFOs, one word per cycle, with per-pop credit returns.
// Latency: block accepted at N, slot j (rank among valid slots) pushed at N+1+j, vc_valid the cycle after.
// Backpressure: mib_ready low while any slot is pending; a full target FIFO holds the slot and raises stall.
// Ports: clk, rst_n, bus (rx_vc_unpacker_if.slave: mib_* block in, vc_* words out, cred_ret, stall, stat_words).
// Option: RX_VC_STATS_EN adds saturating per-VC push counters on stat_words; otherwise stat_words is 0.
// Interface NUM_VC/STAT_WIDTH must match this module's parameters.
module rx_vc_unpacker
  import rx_vc_unpacker_pkg::*;
#(
  parameter int NUM_VC     = 14,
  parameter int FIFO_DEPTH = 32,
  parameter int STAT_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  rx_vc_unpacker_if.slave  bus
);

  rx_state_e                       state_q, state_d;
  logic                            rdy_q, rdy_d;
  rx_slot_t [RX_SLOTS-1:0]         hold_q, hold_d;
  logic [RX_SLOTS-1:0]             pending_q, pending_d;
  logic [NUM_VC-1:0]               cred_ret_q, cred_ret_d;

  logic [SLOT_IDX_W-1:0]           sel_idx;
  logic [VC_NO_WIDTH-1:0]          cur_vc;
  logic [WORD_WIDTH-1:0]           push_data;
  logic [NUM_VC-1:0]               vc_hit;
  logic [NUM_VC-1:0]               full_vec;
  logic [NUM_VC-1:0]               vc_valid_w;
  logic [NUM_VC-1:0][WORD_WIDTH-1:0] vc_data_w;
  logic [NUM_VC-1:0]               push_vec;
  logic                            blocked;
  logic                            mib_ready_c;
  logic                            stall_c;

  // Registered qualifier only, so mib_ready has no path from any input.
  assign mib_ready_c = rdy_q && (pending_q == '0);

  assign sel_idx   = first_set(pending_q);
  assign cur_vc    = hold_q[sel_idx].vc;
  assign push_data = hold_q[sel_idx].data;

  always_comb begin
    vc_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      vc_hit[v] = (int'(cur_vc) == v);
    end
  end

  // full_vec is registered inside each FIFO, so a same-cycle pop never frees room for this push.
  assign blocked = |(full_vec & vc_hit);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    push_vec  = '0;
    stall_c   = 1'b0;
    rdy_d     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.mib_valid && mib_ready_c) begin
          for (int i = 0; i < RX_SLOTS; i++) begin
            hold_d[i]    = '{vc: bus.mib_vc_no[i], data: bus.mib_data[i]};
            pending_d[i] = (int'(bus.mib_vc_no[i]) < NUM_VC);
          end
          // An all-empty block is consumed without leaving IDLE.
          if (pending_d != '0) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Strict slot order: a blocked slot holds back every later slot.
        if (blocked) begin
          stall_c = 1'b1;
        end else begin
          push_vec           = vc_hit;
          pending_d[sel_idx] = 1'b0;
        end
        if (pending_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cred_ret_d = vc_valid_w & bus.vc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      hold_q     <= '0;
      pending_q  <= '0;
      cred_ret_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      cred_ret_q <= cred_ret_d;
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    rx_vc_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_vec[v]),
      .din   (push_data),
      .pop   (bus.vc_ready[v]),
      .dout  (vc_data_w[v]),
      .valid (vc_valid_w[v]),
      .full  (full_vec[v])
    );
  end

  assign bus.mib_ready = mib_ready_c;
  assign bus.vc_data   = vc_data_w;
  assign bus.vc_valid  = vc_valid_w;
  assign bus.cred_ret  = cred_ret_q;
  assign bus.stall     = stall_c;

`ifdef RX_VC_STATS_EN
  logic [NUM_VC-1:0][STAT_WIDTH-1:0] stat_q, stat_d;

  // Saturate rather than wrap so a long run never reads as a small count.
  always_comb begin
    stat_d = stat_q;
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_vec[v] && (stat_q[v] != '1)) begin
        stat_d[v] = stat_q[v] + STAT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign bus.stat_words = stat_q;
`else
  assign bus.stat_words = '0;
`endif

endmodule
